// File: rtl/sfx_memport_pkg.sv
// Shared types and helpers for the sfx_mem_port bus master.
package sfx_memport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_STROBE,
        ST_RD_REL,
        ST_NEXT,
        ST_RESP
    } state_t;

    // Width of the beats-minus-one length field for a given burst limit.
    function automatic int unsigned len_width(input int unsigned max_beats);
        return $clog2(max_beats) + 1;
    endfunction

    // Next beat address; callers truncate to their address width, so wrap is modulo 2^AW.
    function automatic logic [63:0] beat_addr_inc(input logic [63:0] addr, input int unsigned dw);
        return addr + 64'(dw / 8);
    endfunction

endpackage

// File: rtl/sfx_memport_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count.
module sfx_memport_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A full FIFO never accepts, even in a cycle where it also pops.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sfx_mem_port.sv
// Queued multi-beat bus master for sfx CPUs/DMA on the sel/ack/stb memory bus.
// Optional watchdog abort is enabled by defining SFX_MEMPORT_TIMEOUT_EN.
module sfx_mem_port
    import sfx_memport_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned AW        = 32,
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned QDEPTH    = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [AW-1:0]                   req_addr_i,
    input  logic [len_width(MAX_BEATS)-1:0] req_len_i,
    input  logic [MAX_BEATS*DW-1:0]         req_wdata_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [MAX_BEATS*DW-1:0]         rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic                            bus_sel_no,
    input  logic                            bus_ack_i,
    input  logic                            bus_cyc_i,
    output logic [AW-1:0]                   bus_addr_o,
    output logic [DW-1:0]                   bus_dat_o,
    output logic                            bus_we_no,
    output logic                            bus_stb_o,
    input  logic                            bus_stb_i,
    input  logic [DW-1:0]                   bus_dat_i
);
    localparam int unsigned LW   = len_width(MAX_BEATS);
    localparam int unsigned DATW = MAX_BEATS * DW;
    localparam int unsigned CW   = $clog2(QDEPTH + 1);

    if ((DW % 8) != 0 || MAX_BEATS < 1 || QDEPTH < 1 || TIMEOUT < 1) begin : g_param_check
        $error("sfx_mem_port: illegal parameter set");
    end

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [LW-1:0]   len;
        logic [DATW-1:0] wdata;
    } req_t;

    req_t          in_req;
    req_t          head;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;

    state_t          state_q, state_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [LW-1:0]   len_q, len_d;
    logic [DATW-1:0] wdata_q, wdata_d;
    logic [DATW-1:0] rdata_q, rdata_d;
    logic            sel_n_q, sel_n_d;
    logic            we_n_q, we_n_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [DW-1:0]   bus_dat_q, bus_dat_d;
    logic            rsp_valid_q, rsp_valid_d;

`ifdef SFX_MEMPORT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign req_ready_o = (fifo_count < CW'(QDEPTH));
    assign push        = req_valid_i && req_ready_o;

    always_comb begin
        in_req.we    = req_we_i;
        in_req.addr  = req_addr_i;
        in_req.len   = (req_len_i > LW'(MAX_BEATS - 1)) ? LW'(MAX_BEATS - 1) : req_len_i;
        in_req.wdata = req_wdata_i;
    end

    sfx_memport_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push),
        .push_data (in_req),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        we_d        = we_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        sel_n_d     = sel_n_q;
        we_n_d      = we_n_q;
        stb_d       = stb_q;
        bus_addr_d  = bus_addr_q;
        bus_dat_d   = bus_dat_q;
        rsp_valid_d = rsp_valid_q;
        pop         = 1'b0;
`ifdef SFX_MEMPORT_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    we_d    = head.we;
                    len_d   = head.len;
                    wdata_d = head.wdata;
                    addr_d  = head.addr;
                    beat_d  = '0;
                    rdata_d = '0;
                    sel_n_d = 1'b0;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!bus_cyc_i && bus_ack_i) begin
                    sel_n_d    = 1'b1;
                    bus_addr_d = addr_q;
                    stb_d      = 1'b1;
                    if (we_q) begin
                        we_n_d    = 1'b0;
                        bus_dat_d = wdata_q[beat_q*DW +: DW];
                    end
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (bus_stb_i) begin
                    stb_d = 1'b0;
                    if (we_q) begin
                        we_n_d     = 1'b1;
                        bus_addr_d = '0;
                        bus_dat_d  = '0;
                        state_d    = ST_NEXT;
                    end else begin
                        state_d = ST_RD_REL;
                    end
                end
            end
            ST_RD_REL: begin
                if (!bus_cyc_i) begin
                    rdata_d[beat_q*DW +: DW] = bus_dat_i;
                    bus_addr_d = '0;
                    state_d    = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (beat_q == len_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    addr_d  = AW'(beat_addr_inc(64'(addr_q), DW));
                    sel_n_d = 1'b0;
                    state_d = ST_ARB;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
`ifdef SFX_MEMPORT_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SFX_MEMPORT_TIMEOUT_EN
        // The watchdog only fires when the bus made no progress this cycle.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (state_q inside {ST_ARB, ST_STROBE, ST_RD_REL}) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                sel_n_d     = 1'b1;
                stb_d       = 1'b0;
                we_n_d      = 1'b1;
                bus_addr_d  = '0;
                bus_dat_d   = '0;
                rsp_valid_d = 1'b1;
                err_d       = 1'b1;
                tmo_d       = '0;
                state_d     = ST_RESP;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            len_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            sel_n_q     <= 1'b1;
            we_n_q      <= 1'b1;
            stb_q       <= 1'b0;
            bus_addr_q  <= '0;
            bus_dat_q   <= '0;
            rsp_valid_q <= 1'b0;
`ifdef SFX_MEMPORT_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sel_n_q     <= sel_n_d;
            we_n_q      <= we_n_d;
            stb_q       <= stb_d;
            bus_addr_q  <= bus_addr_d;
            bus_dat_q   <= bus_dat_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef SFX_MEMPORT_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign bus_sel_no  = sel_n_q;
    assign bus_we_no   = we_n_q;
    assign bus_stb_o   = stb_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_dat_o   = bus_dat_q;

endmodule

// File: tb/tb_sfx_mem_port.sv
// Directed scoreboard bench for sfx_mem_port with a behavioural sel/ack/stb slave.
module tb_sfx_mem_port;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 32;
    localparam int unsigned MB  = 4;
    localparam int unsigned QD  = 2;
    localparam int unsigned TMO = 8;
    localparam int unsigned LW  = $clog2(MB) + 1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } bus_op_t;

    typedef struct {
        logic [MB*DW-1:0] rdata;
        logic             err;
    } rsp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b1;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_we_i = 1'b0;
    logic [AW-1:0]    req_addr_i = '0;
    logic [LW-1:0]    req_len_i = '0;
    logic [MB*DW-1:0] req_wdata_i = '0;
    logic             rsp_valid_o;
    logic             rsp_ready_i = 1'b0;
    logic [MB*DW-1:0] rsp_rdata_o;
    logic             rsp_err_o;
    logic             bus_sel_no;
    logic             bus_ack_i = 1'b0;
    logic             bus_cyc_i = 1'b0;
    logic [AW-1:0]    bus_addr_o;
    logic [DW-1:0]    bus_dat_o;
    logic             bus_we_no;
    logic             bus_stb_o;
    logic             bus_stb_i = 1'b0;
    logic [DW-1:0]    bus_dat_i = '0;

    int vectors = 0;
    int miscompares = 0;
    bus_op_t exp_bus[$];
    rsp_t    exp_rsp[$];

    int unsigned slave_wait = 0;
    bit          ack_en = 1'b1;
    int          strobes = 0;
    int          arbs = 0;
    int unsigned wcnt = 0;
    bit          in_strobe = 1'b0;
    logic        prev_sel = 1'b1;

    always #5 clk_i = ~clk_i;

    sfx_mem_port #(
        .DW        (DW),
        .AW        (AW),
        .MAX_BEATS (MB),
        .QDEPTH    (QD),
        .TIMEOUT   (TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_len_i   (req_len_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .bus_sel_no  (bus_sel_no),
        .bus_ack_i   (bus_ack_i),
        .bus_cyc_i   (bus_cyc_i),
        .bus_addr_o  (bus_addr_o),
        .bus_dat_o   (bus_dat_o),
        .bus_we_no   (bus_we_no),
        .bus_stb_o   (bus_stb_o),
        .bus_stb_i   (bus_stb_i),
        .bus_dat_i   (bus_dat_i)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
        return (a == 32'h4000_0000) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    task automatic mon_strobe();
        bus_op_t e;
        check("bus_op_expected", exp_bus.size() > 0, 1'b1);
        if (exp_bus.size() == 0) return;
        e = exp_bus.pop_front();
        check("bus_we_n", bus_we_no, !e.we);
        check("bus_addr", bus_addr_o, e.addr);
        check("bus_dat", bus_dat_o, e.we ? e.dat : '0);
        check("bus_sel_released", bus_sel_no, 1'b1);
    endtask

    // Slave: grants sel requests, answers each strobe after slave_wait cycles, never busy.
    always @(negedge clk_i) begin
        bus_ack_i = ack_en && !bus_sel_no;
        if (!bus_sel_no && prev_sel) arbs++;
        prev_sel = bus_sel_no;
        if (!bus_stb_o) begin
            bus_stb_i = 1'b0;
            in_strobe = 1'b0;
            wcnt      = 0;
        end else if (!bus_stb_i) begin
            if (!in_strobe) begin
                in_strobe = 1'b1;
                strobes++;
                mon_strobe();
            end
            if (wcnt == slave_wait) begin
                bus_stb_i = 1'b1;
                bus_dat_i = slave_data(bus_addr_o);
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic push_req(input bit we, input logic [AW-1:0] addr, input int unsigned len,
                            input logic [MB*DW-1:0] wdata, input bit aborts);
        rsp_t          r;
        bus_op_t       op;
        int unsigned   eff;
        logic [AW-1:0] a;
        int            n;
        eff     = (len > MB - 1) ? MB - 1 : len;
        r.rdata = '0;
        r.err   = aborts;
        a       = addr;
        if (!aborts) begin
            for (int unsigned k = 0; k <= eff; k++) begin
                op.we   = we;
                op.addr = a;
                op.dat  = wdata[k*DW +: DW];
                exp_bus.push_back(op);
                if (!we) r.rdata[k*DW +: DW] = slave_data(a);
                a = a + AW'(DW / 8);
            end
        end
        exp_rsp.push_back(r);
        req_we_i    = we;
        req_addr_i  = addr;
        req_len_i   = LW'(len);
        req_wdata_i = wdata;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("req_accepted", req_ready_o, 1'b1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // lat = negedges after the one following the accept edge until rsp_valid_o is seen.
    task automatic take_rsp(input string tag, input int hold, output int lat);
        rsp_t e;
        int   n;
        n = 0;
        while (!rsp_valid_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        lat = n;
        check({tag, "_valid"}, rsp_valid_o, 1'b1);
        check({tag, "_expected"}, exp_rsp.size() > 0, 1'b1);
        if (exp_rsp.size() == 0) return;
        e = exp_rsp.pop_front();
        check({tag, "_rdata"}, rsp_rdata_o, e.rdata);
        check({tag, "_err"}, rsp_err_o, e.err);
        if (hold > 0) begin
            repeat (hold) @(negedge clk_i);
            check({tag, "_held_valid"}, rsp_valid_o, 1'b1);
            check({tag, "_held_rdata"}, rsp_rdata_o, e.rdata);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        check({tag, "_released"}, rsp_valid_o, 1'b0);
        check({tag, "_err_cleared"}, rsp_err_o, 1'b0);
    endtask

    initial begin
        int lat;
        int a0;
        int s0;
        int s_rst;
        int n;

        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_rsp_rdata", rsp_rdata_o, '0);
        check("rst_rsp_err", rsp_err_o, 1'b0);
        check("rst_sel_n", bus_sel_no, 1'b1);
        check("rst_we_n", bus_we_no, 1'b1);
        check("rst_stb", bus_stb_o, 1'b0);
        check("rst_addr", bus_addr_o, '0);
        check("rst_dat", bus_dat_o, '0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single read with two slave wait cycles.
        slave_wait = 2;
        push_req(1'b0, 32'h4000_0000, 0, '0, 1'b0);
        take_rsp("rd_beef", 0, lat);

        // Immediate grant/ack: accept edge plus five more edges (six cycles).
        slave_wait = 0;
        push_req(1'b0, 32'h0000_1230, 0, '0, 1'b0);
        take_rsp("rd_min", 0, lat);
        check("rd_min_latency", lat, 5);

        // Four-beat write; one arbitration per beat, 3 edges per beat.
        a0 = arbs;
        push_req(1'b1, 32'h0000_0100, 3, 64'h4444_3333_2222_1111, 1'b0);
        take_rsp("wr_burst", 0, lat);
        check("wr_burst_latency", lat, 13);
        check("wr_burst_arbs", arbs - a0, 4);

        // Two-beat read wrapping past the top of the address space.
        push_req(1'b0, 32'hFFFF_FFFE, 1, '0, 1'b0);
        take_rsp("rd_wrap", 0, lat);
        check("rd_wrap_latency", lat, 9);

        // Three back-to-back pushes with the response stalled; the third has len clamped.
        push_req(1'b0, 32'h0000_0010, 0, '0, 1'b0);
        push_req(1'b1, 32'h0000_0020, 1, 64'h0000_0000_BBBB_AAAA, 1'b0);
        push_req(1'b0, 32'h0000_0030, 5, '0, 1'b0);
        check("queue_full_ready", req_ready_o, 1'b0);
        take_rsp("q_a", 6, lat);
        take_rsp("q_b", 0, lat);
        take_rsp("q_c", 0, lat);

        // Reset during the strobe of beat 1 with two more requests queued.
        slave_wait = 3;
        s0 = strobes;
        push_req(1'b0, 32'h0000_0500, 1, '0, 1'b0);
        push_req(1'b1, 32'h0000_0600, 0, 64'h1234, 1'b0);
        push_req(1'b0, 32'h0000_0700, 0, '0, 1'b0);
        check("pre_rst_full", req_ready_o, 1'b0);
        n = 0;
        while (strobes < s0 + 2 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("pre_rst_in_strobe", bus_stb_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_stb", bus_stb_o, 1'b0);
        check("mid_rst_sel_n", bus_sel_no, 1'b1);
        check("mid_rst_we_n", bus_we_no, 1'b1);
        check("mid_rst_addr", bus_addr_o, '0);
        check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
        check("mid_rst_ready", req_ready_o, 1'b1);
        exp_bus.delete();
        exp_rsp.delete();
        s_rst = strobes;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        check("post_rst_no_rsp", rsp_valid_o, 1'b0);
        check("post_rst_idle_sel", bus_sel_no, 1'b1);
        check("post_rst_no_strobe", strobes - s_rst, 0);
        slave_wait = 0;

`ifdef SFX_MEMPORT_TIMEOUT_EN
        // Grant withheld: eight ARB cycles then an error response with no data.
        ack_en = 1'b0;
        push_req(1'b0, 32'h0000_0200, 1, '0, 1'b1);
        take_rsp("tmo", 0, lat);
        check("tmo_latency", lat, 9);
        check("tmo_sel_n", bus_sel_no, 1'b1);
        ack_en = 1'b1;
`endif

        repeat (5) @(negedge clk_i);
        check("sb_bus_drained", exp_bus.size(), 0);
        check("sb_rsp_drained", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
